regs_gen: RTL and testbench

Parametrised successor to the picoMIPS general-purpose register file: `2**AW` registers of `N` bits, register 0 hardwired to zero, two combinational read ports and one write port. A built-in sequential clear engine zeroes the whole file after reset or on request, one register per cycle. Writes use a ready handshake. An optional write-to-read bypass is available. Sits between decode (read addresses) and the ALU/writeback path of the CPU datapath.

---
 rtl/regs_pkg.sv | 8 +
 rtl/regs_clear_seq.sv | 36 +++
 rtl/regs_gen.sv | 55 +++++
 tb/tb_regs_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// regs_pkg: shared types for the register file (clear-engine states, N-bit zero helper)
package regs_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} regs_state_t;
  localparam int unsigned REGS_MAX_N = 1024;
  function automatic logic [REGS_MAX_N-1:0] regs_zero();
    return '0;
  endfunction
endpackage

// File: rtl/regs_clear_seq.sv
// regs_clear_seq: sequential clear walk over registers 1..2**AW-1 after reset or on clr
// ports: clk, nReset (sync, active-low), clr (request, IDLE only), busy (walk active),
//        clr_we/clr_addr (zero-write strobe and target for the register file)
module regs_clear_seq #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  import regs_pkg::*;
  regs_state_t   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          last;
  always_comb begin
    last    = ptr_q == '1;
    state_d = state_q == CLEAR ? (last ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
    ptr_d   = state_q == CLEAR ? (last ? ptr_q : ptr_q + AW'(1)) : (clr ? AW'(1) : ptr_q);
  end
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  assign busy     = state_q == CLEAR;
  // reset edges must not touch the array, so the zero-write is held off while nReset is low
  assign clr_we   = busy && nReset;
  assign clr_addr = ptr_q;
endmodule

// File: rtl/regs_gen.sv
// regs_gen: 2**AW x N register file, r0 hardwired zero, 2 comb read ports, 1 write port, clear engine
// ports: clk, nReset (sync, active-low), clr, w1/waddr/wdata with w_ready handshake,
//        raddr1/raddr2 -> rdata1/rdata2 (combinational), busy (clear in progress)
// optional: define REGS_BYPASS_EN to forward an accepted write's wdata to matching read ports
module regs_gen #(
  parameter int N  = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          clr,
  input  logic          w1,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  output logic          w_ready,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [N-1:0]  rdata1,
  output logic [N-1:0]  rdata2,
  output logic          busy
);
  import regs_pkg::*;
  localparam int DEPTH = 2 ** AW;
  logic [N-1:0]  gpr [DEPTH-1:0];
  logic          clr_we, user_we, we, hit1, hit2;
  logic [AW-1:0] clr_addr, wa;
  logic [N-1:0]  wd;
  regs_clear_seq #(.AW(AW)) u_clear (
    .clk      (clk),
    .nReset   (nReset),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  assign w_ready = !busy;
  always_comb begin
    user_we = w1 && w_ready && waddr != '0;
    we      = clr_we || user_we;
    wa      = clr_we ? clr_addr : waddr;
    wd      = clr_we ? N'(regs_zero()) : wdata;
`ifdef REGS_BYPASS_EN
    hit1    = user_we && waddr == raddr1;
    hit2    = user_we && waddr == raddr2;
`else
    hit1    = 1'b0;
    hit2    = 1'b0;
`endif
    rdata1  = busy || raddr1 == '0 ? N'(regs_zero()) : hit1 ? wdata : gpr[raddr1];
    rdata2  = busy || raddr2 == '0 ? N'(regs_zero()) : hit2 ? wdata : gpr[raddr2];
  end
  always_ff @(posedge clk) begin
    if (we) gpr[wa] <= wd;
  end
endmodule

// File: tb/tb_regs_gen.sv
// tb_regs_gen: randomized self-checking bench for regs_gen against a behavioural model
module tb_regs_gen;
`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic       clk = 0, nReset = 0, clr = 0, w1 = 0;
  logic [4:0] waddr = 0, raddr1 = 0, raddr2 = 0;
  logic [7:0] wdata = 0;
  logic       w_ready, busy;
  logic [7:0] rdata1, rdata2;
  int total = 0, bad = 0;
  logic [7:0] m [32];
  int  left = 0;
  bit  known = 0;
  always #5 clk = ~clk;
  regs_gen #(.N(8), .AW(5)) dut (
    .clk(clk), .nReset(nReset), .clr(clr), .w1(w1), .waddr(waddr), .wdata(wdata),
    .w_ready(w_ready), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .busy(busy)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] exp_rd(logic [4:0] a);
    if (left > 0 || a == 0) return 8'h00;
    if (BYP && w1 && waddr == a) return wdata;
    return m[a];
  endfunction
  task automatic cycle();
    @(negedge clk);
    if (known) begin
      chk("busy", {31'd0, busy}, {31'd0, left > 0});
      chk("w_ready", {31'd0, w_ready}, {31'd0, left == 0});
      chk("rdata1", {24'd0, rdata1}, {24'd0, exp_rd(raddr1)});
      chk("rdata2", {24'd0, rdata2}, {24'd0, exp_rd(raddr2)});
    end
    if (!nReset) begin
      left = 31;
      known = 1;
    end else if (left > 0) begin
      m[32 - left] = 8'h00;
      left--;
    end else begin
      if (w1 && waddr != 0) m[waddr] = wdata;
      if (clr) left = 31;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
  endtask
  initial begin
    int n;
    repeat (3) cycle();
    nReset = 1;
    run_busy(n);
    chk("reset_walk_len", n, 31);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      chk("post_reset_zero", {24'd0, rdata1}, 0);
      cycle();
    end
    w1 = 1; waddr = 7; wdata = 8'hA5; raddr1 = 7;
    #1;
    chk("wr_same_cycle", {24'd0, rdata1}, BYP ? 32'hA5 : 32'h00);
    cycle();
    w1 = 0;
    #1;
    chk("wr_after_edge", {24'd0, rdata1}, 32'hA5);
    cycle();
    w1 = 1; waddr = 0; wdata = 8'hFF; raddr1 = 0;
    cycle();
    w1 = 0;
    #1;
    chk("r0_stays_zero", {24'd0, rdata1}, 0);
    w1 = 1; waddr = 9; wdata = 8'h3C; raddr2 = 9;
    #1;
    chk("bypass_rdata2", {24'd0, rdata2}, BYP ? 32'h3C : 32'h00);
    cycle();
    w1 = 0;
    #1;
    chk("r9_after_edge", {24'd0, rdata2}, 32'h3C);
    clr = 1;
    cycle();
    clr = 0; w1 = 1; waddr = 4; wdata = 8'h11;
    n = 0;
    repeat (40) begin
      if (!w_ready) n++;
      cycle();
    end
    w1 = 0;
    chk("handshake_stall", n, 31);
    for (int i = 0; i < 32; i++) begin
      raddr2 = 5'(i);
      #1;
      chk("handshake_regs", {24'd0, rdata2}, i == 4 ? 32'h11 : 32'h00);
    end
    w1 = 1; waddr = 31; wdata = 8'h7E; clr = 1;
    cycle();
    w1 = 0; clr = 0;
    run_busy(n);
    chk("clr_with_write_len", n, 31);
    raddr1 = 31;
    #1;
    chk("r31_cleared", {24'd0, rdata1}, 0);
    clr = 1;
    cycle();
    clr = 0;
    repeat (10) cycle();
    clr = 1;
    cycle();
    clr = 0;
    run_busy(n);
    chk("clr_midwalk_len", n + 11, 31);
    clr = 1;
    cycle();
    clr = 0;
    repeat (10) cycle();
    nReset = 0;
    cycle();
    nReset = 1;
    run_busy(n);
    chk("reset_midwalk_len", n, 31);
    repeat (600) begin
      nReset = $urandom_range(99) != 0;
      clr    = $urandom_range(39) == 0;
      w1     = nReset ? 1'($urandom_range(1)) : 1'b0;
      waddr  = 5'($urandom_range(31));
      wdata  = 8'($urandom);
      raddr1 = $urandom_range(3) == 0 ? waddr : 5'($urandom_range(31));
      raddr2 = $urandom_range(3) == 0 ? waddr : 5'($urandom_range(31));
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
